// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: state encoding, default word
// width, counter-width helper and the even-parity helper used by the
// optional parity bit.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_W_DEFAULT = 8;

  // Counter must hold 0..W so it can also index the optional parity slot.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Even parity over a zero-extended word (zero padding does not change it).
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the 1011 pattern detectors.
// Words arrive over valid/ready and leave one bit per enabled clock on a
// registered line. Ready is raised during the final bit of a frame so
// consecutive words stream with no idle bit in between.
// Optional feature: define SER_PARITY_EN to append an even-parity bit to
// every frame (frame length W+1 instead of W).
module bit_serializer
  import ser_pkg::*;
#(
  parameter int W         = SER_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         last_bit,
  output logic         busy
);

`ifdef SER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif
  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  ser_state_t    state_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  shreg_r;
  logic          dout_r;
  logic          dout_valid_r;
`ifdef SER_PARITY_EN
  logic          par_r;
`endif

  logic          at_last_s;
  logic          accept_s;
  logic          first_bit_s;
  logic [W-1:0]  load_shreg_s;
  logic          next_bit_s;
  logic [W-1:0]  shifted_s;
  logic          next_out_s;

  // Handshake decode and bit selection for the configured shift direction.
  always_comb begin
    at_last_s  = (state_r == SHIFT) && (cnt_r == LAST);
    data_ready = en && ((state_r == IDLE) || at_last_s);
    accept_s   = data_valid && data_ready;
    if (MSB_FIRST) begin
      first_bit_s  = data_in[W-1];
      load_shreg_s = {data_in[W-2:0], 1'b0};
      next_bit_s   = shreg_r[W-1];
      shifted_s    = {shreg_r[W-2:0], 1'b0};
    end else begin
      first_bit_s  = data_in[0];
      load_shreg_s = {1'b0, data_in[W-1:1]};
      next_bit_s   = shreg_r[0];
      shifted_s    = {1'b0, shreg_r[W-1:1]};
    end
`ifdef SER_PARITY_EN
    // After the last data bit the parity bit takes the serial slot.
    if (cnt_r == CW'(W - 1)) begin
      next_out_s = par_r;
    end else begin
      next_out_s = next_bit_s;
    end
`else
    next_out_s = next_bit_s;
`endif
  end

  // Frame FSM, shift register and registered serial outputs; en=0 holds all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      shreg_r      <= '0;
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
`ifdef SER_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else if (en) begin
      if (accept_s) begin
        state_r      <= SHIFT;
        cnt_r        <= '0;
        shreg_r      <= load_shreg_s;
        dout_r       <= first_bit_s;
        dout_valid_r <= 1'b1;
`ifdef SER_PARITY_EN
        par_r        <= even_parity(32'(data_in));
`endif
      end else if ((state_r == SHIFT) && !at_last_s) begin
        cnt_r   <= cnt_r + CW'(1);
        shreg_r <= shifted_s;
        dout_r  <= next_out_s;
      end else if (at_last_s) begin
        state_r      <= IDLE;
        cnt_r        <= '0;
        dout_r       <= 1'b0;
        dout_valid_r <= 1'b0;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign last_bit   = dout_valid_r && (cnt_r == LAST);
  assign busy       = (state_r == SHIFT);

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream stage for the serial pattern detectors (1011 Moore detector family).
- Accepts parallel words over a valid/ready handshake and emits them one bit per enabled clock on a registered serial line. This line drives the detector's `din` directly.
- Back-to-back words are streamed with no idle bit between them, so overlapping patterns that span a word boundary are still presented contiguously.

Parameters:
- `W`, 8, parallel word width in bits (legal range 2..32).
- `MSB_FIRST`, 1, 1 = bit `W-1` shifted out first; 0 = bit 0 first.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  shift enable; 0 freezes all internal and output state.
- `data_in`  in  W  parallel word to serialize.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  serializer can accept `data_in` this cycle (combinational).
- `dout`  out  1  serial bit, registered.
- `dout_valid`  out  1  `dout` carries a real bit, registered.
- `last_bit`  out  1  `dout` holds the final bit of the current frame (decoded from registers).
- `busy`  out  1  a frame is in progress (state `SHIFT`).

Behaviour:
- **Clock and reset:** one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- **Reset values:**
  - `dout`=0, `dout_valid`=0, `last_bit`=0, `busy`=0.
  - State = `IDLE`, bit counter = 0, shift register = 0.
  - `data_ready` = `en` while in reset-released `IDLE`.
- **Frame length:** `F` = `W`, or `W+1` with the optional feature.
- **States:**
  - `IDLE`: `dout_valid`=0, `dout`=0.
  - `SHIFT`: the counter `cnt` (0..F-1) indexes the bit currently on `dout`.
- **Ready rule:** `data_ready` = `en` AND (state==`IDLE` OR (state==`SHIFT` AND `cnt`==F-1)).
  - Ready is asserted during the last bit, which enables gapless streaming.
- **Accept:** accept = `data_valid` AND `data_ready` at a rising edge.
  - On accept, load the word.
  - Next cycle: `dout` = first bit (`data_in[W-1]` if `MSB_FIRST`, else `data_in[0]`), `dout_valid`=1, `cnt`=0, state=`SHIFT`.
- **Latency:** first bit appears on `dout` exactly 1 cycle after the accept edge.
- **`SHIFT`, `en`=1, `cnt`<F-1:** shift one position; `dout` = next bit; `cnt`+1.
- **`SHIFT`, `en`=1, `cnt`==F-1, accept:** load new word; the next cycle shows its first bit with `cnt`=0 (no gap).
- **`SHIFT`, `en`=1, `cnt`==F-1, no accept:** go to `IDLE`; next cycle `dout_valid`=0, `dout`=0.
- **`en`=0, any state:** all registers hold, and `data_ready`=0.
  - `dout`/`dout_valid` stay at their current values.
  - Downstream must gate on the same `en`.
- **`last_bit`** = `dout_valid` AND `cnt`==F-1.
- **`data_valid` while not ready:** ignored. The word is not captured, and the upstream source must hold it.
- **`rst_n` low mid-frame:** the partial word is discarded immediately (asynchronous). No residual bits are emitted after release.
- **`data_in`** is sampled only at an accept edge; changes at other times have no effect.

Optional Feature:
- **Macro:** `SER_PARITY_EN`.
- **Defined:**
  - Each frame appends one even-parity bit (XOR of all `W` data bits) after the last data bit, so `F`=`W+1`.
  - The parity bit has `dout_valid`=1 and `last_bit`=1.
  - `data_ready` asserts during the parity bit, not during the last data bit.
- **Undefined:** `F`=`W`; no parity logic is present.

Decomposition:
- **Shared package `ser_pkg`:**
  - State enum `ser_state_t {IDLE, SHIFT}`.
  - Constant `SER_W_DEFAULT`=8.
  - Function `even_parity(word)`.
  - Counter width derived as `$clog2(W+1)`.
- **Sub-modules:** none required; a single module.

Test Plan:
- **Single word:** `W`=8, `MSB_FIRST`=1, `en`=1, accept 8'hB6 → `dout` sequence 1,0,1,1,0,1,1,0 on cycles 1..8 after accept. `last_bit` is high on cycle 8, and `dout_valid`=0 on cycle 9.
- **Back-to-back:** 8'hB0 then 8'hB0 held valid → 16 contiguous valid bits with no gap. Second accept occurs on the cycle `cnt`==7.
- **Enable stall:** drop `en` for 3 cycles after the 3rd bit of 8'h0B → `dout` and `dout_valid` frozen, `data_ready`=0. Sequence resumes with 0,1,0,1,1; total valid bits = 8.
- **LSB first:** `MSB_FIRST`=0, accept 8'h0D → bits 1,0,1,1,0,0,0,0.
- **Mid-frame reset:** assert `rst_n`=0 after the 4th bit → all outputs 0 immediately; after release `data_ready`=1 and no stale bits appear.
- **Parity (`SER_PARITY_EN`):** accept 8'hB6 (five ones) → 9 bits ending with parity 1, with `last_bit` on the 9th. Accept 8'h03 → parity bit 0.
